// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : Philips I2S transmitter. Accepts stereo samples through a
//                valid/ready handshake into a one-frame holding register and
//                serialises them MSB first, one bit after the LRCK edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int SCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    mute,
  output logic                    i2s_sclk,
  output logic                    i2s_lrck,
  output logic                    i2s_dac,
  output logic                    frame_start,
  output logic [15:0]             underflow_count
);

  localparam int c_FRAME_BITS = 2 * SLOT_BITS;
  localparam int c_BW         = $clog2(c_FRAME_BITS);
  localparam int c_DW         = $clog2(SCLK_DIV);

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCLK_DIV - 1);
  localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(SCLK_DIV / 2);
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FRAME_BITS - 1);
  localparam logic [c_BW-1:0] c_SLOT     = c_BW'(SLOT_BITS);

  logic [c_DW-1:0]         r_div_cnt;
  logic [c_BW-1:0]         r_bit_cnt;
  logic                    r_hold_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;
  logic [SAMPLE_WIDTH-1:0] r_active_l;
  logic [SAMPLE_WIDTH-1:0] r_active_r;
  logic                    r_mute_q;

  logic                    w_div_wrap;
  logic [c_DW-1:0]         w_div_next;
  logic [c_BW-1:0]         w_bit_next;
  logic                    w_load;
  logic                    w_accept;
  logic                    w_next_right;
  logic [c_BW-1:0]         w_slot;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic                    w_dac_next;

  assign sample_ready = ~r_hold_full & ~reset;
  assign w_accept     = sample_valid & sample_ready;

  assign w_div_wrap   = (r_div_cnt == c_DIV_LAST);
  assign w_div_next   = w_div_wrap ? '0 : r_div_cnt + 1'b1;
  assign w_bit_next   = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
  // The frame boundary: last clk of the last bit of the frame.
  assign w_load       = w_div_wrap & (r_bit_cnt == c_BIT_LAST);

  // Serial bit for the slot position that bit_cnt is about to enter.
  always_comb begin
    w_dac_next   = 1'b0;
    w_next_right = (w_bit_next >= c_SLOT);
    w_slot       = w_next_right ? (w_bit_next - c_SLOT) : w_bit_next;
    w_word       = w_next_right ? r_active_r : r_active_l;
    // Slot bit s (1..SAMPLE_WIDTH) carries word bit SAMPLE_WIDTH-s; s==0 is the I2S delay bit.
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (w_slot == c_BW'(SAMPLE_WIDTH - i)) begin
        w_dac_next = w_word[i];
      end
    end
    if (r_mute_q) begin
      w_dac_next = 1'b0;
    end
  end

  // Bit-clock divider, bit counter and the registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      i2s_sclk    <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_dac     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_next;
      i2s_sclk    <= (w_div_next >= c_DIV_HALF);
      frame_start <= w_load;
      if (w_div_wrap) begin
        r_bit_cnt <= w_bit_next;
        i2s_lrck  <= (w_bit_next >= c_SLOT);
        i2s_dac   <= w_dac_next;
      end
    end
  end

  // Holding register, frame load into the active pair, mute latch and underflow count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_full     <= 1'b0;
      r_hold_l        <= '0;
      r_hold_r        <= '0;
      r_active_l      <= '0;
      r_active_r      <= '0;
      r_mute_q        <= 1'b0;
      underflow_count <= '0;
    end else begin
      // Accept needs an empty hold and a transfer needs a full one, so they never collide.
      if (w_accept) begin
        r_hold_l    <= sample_l;
        r_hold_r    <= sample_r;
        r_hold_full <= 1'b1;
      end else if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
      if (w_load) begin
        r_mute_q <= mute;
        if (r_hold_full) begin
          r_active_l <= r_hold_l;
          r_active_r <= r_hold_r;
        end else if (underflow_count != 16'hFFFF) begin
          underflow_count <= underflow_count + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. A time-indexed model
//                predicts every output from the clock count since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

  localparam int SW    = 16;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SLOT * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sample_l = '0;
  logic [SW-1:0] sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          mute = 1'b0;
  logic          sample_ready;
  logic          i2s_sclk;
  logic          i2s_lrck;
  logic          i2s_dac;
  logic          frame_start;
  logic [15:0]   underflow_count;

  int checks = 0;
  int errors = 0;

  audio_i2s_tx #(
    .SAMPLE_WIDTH(SW),
    .SLOT_BITS   (SLOT),
    .SCLK_DIV    (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .mute           (mute),
    .i2s_sclk       (i2s_sclk),
    .i2s_lrck       (i2s_lrck),
    .i2s_dac        (i2s_dac),
    .frame_start    (frame_start),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: k clocks since reset release; a queue of at most one pending pair.
  int              k = 0;
  logic [SW-1:0]   m_act_l = '0;
  logic [SW-1:0]   m_act_r = '0;
  logic            m_mute = 1'b0;
  int              m_uf = 0;
  logic [2*SW-1:0] pend[$];

  // Advance the model on every edge, then compare all outputs just after it.
  always @(posedge clk or posedge reset) begin
    int            bitn;
    int            s;
    logic          acc;
    logic [SW-1:0] word;
    logic          e_dac;
    if (reset) begin
      k = 0; m_act_l = '0; m_act_r = '0; m_mute = 1'b0; m_uf = 0;
      pend.delete();
    end else begin
      acc = sample_valid && (pend.size() == 0);
      k++;
      if (k % FRAME == 0) begin
        if (pend.size() > 0) {m_act_l, m_act_r} = pend.pop_front();
        else if (m_uf < 65535) m_uf++;
        m_mute = mute;
      end
      if (acc) pend.push_back({sample_l, sample_r});
    end
    #1;
    bitn  = (k / DIV) % (2 * SLOT);
    s     = bitn % SLOT;
    word  = (bitn < SLOT) ? m_act_l : m_act_r;
    e_dac = 1'b0;
    if (!m_mute && s >= 1 && s <= SW) e_dac = word[SW - s];
    check_eq("sclk",  {31'd0, i2s_sclk},  {31'd0, (k % DIV) >= DIV / 2});
    check_eq("lrck",  {31'd0, i2s_lrck},  {31'd0, bitn >= SLOT});
    check_eq("dac",   {31'd0, i2s_dac},   {31'd0, e_dac});
    check_eq("fstart",{31'd0, frame_start}, {31'd0, (k % FRAME == 0) && (k > 0)});
    check_eq("ready", {31'd0, sample_ready}, {31'd0, !reset && (pend.size() == 0)});
    check_eq("uflow", {16'd0, underflow_count}, m_uf);
  end

  // Offer a pair, wait (bounded) for ready, report whether frame_start was high at acceptance.
  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r, output logic fs_seen);
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    for (int n = 0; n < 2 * FRAME && !sample_ready; n++) @(negedge clk);
    check_eq("send_ready", {31'd0, sample_ready}, 32'd1);
    fs_seen = frame_start;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_fs();
    for (int n = 0; n < 2 * FRAME && !frame_start; n++) @(negedge clk);
    check_eq("fs_seen", {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    logic        fs;
    logic [63:0] cap;
    logic        prev;
    int          rise;
    int          u0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Serial format of a known pair, then three starved frames.
    send(16'h8001, 16'h7FFE, fs);
    wait_fs();
    cap = '0; prev = 1'b0; rise = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i2s_lrck && rise < 0) rise = i;
      if (i2s_sclk && !prev) cap = {cap[62:0], i2s_dac};
      prev = i2s_sclk;
      @(negedge clk);
    end
    check_eq("lrck_rise", rise, 128);
    check_eq("left_bits", cap[63:32], 32'h40008000);
    check_eq("right_bits", cap[31:0], 32'h3FFF0000);
    while (k < 4 * FRAME + 1) @(negedge clk);
    check_eq("uf_three", {16'd0, underflow_count}, 32'd3);

    // Back-to-back pairs under backpressure.
    u0 = m_uf;
    send(16'h1357, 16'h2468, fs);
    send(16'hC0DE, 16'h0BAD, fs);
    check_eq("b_at_fs", {31'd0, fs}, 32'd1);
    wait_fs();
    @(negedge clk);
    check_eq("bp_no_uf", {16'd0, underflow_count}, u0);

    // A pair offered exactly on the load edge with hold empty.
    for (int n = 0; n < 2 * FRAME && (k % FRAME) != FRAME - 1; n++) @(negedge clk);
    u0 = m_uf;
    sample_l = 16'hA5A5; sample_r = 16'h5A5A; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("simul_uf", {16'd0, underflow_count}, u0 + 1);
    check_eq("simul_ready", {31'd0, sample_ready}, 32'd0);
    repeat (2 * FRAME) @(negedge clk);

    // Mute raised mid-frame at bit 40, then released.
    send(16'h1234, 16'hABCD, fs);
    for (int n = 0; n < 2 * FRAME && ((k / DIV) % (2 * SLOT)) != 40; n++) @(negedge clk);
    mute = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    mute = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    // Randomized traffic with random mute toggles.
    for (int c = 0; c < 24 * FRAME; c++) begin
      @(negedge clk);
      if (!(sample_valid && !sample_ready)) begin
        sample_valid = ($urandom_range(0, 199) == 0);
        sample_l = SW'($urandom);
        sample_r = SW'($urandom);
      end
      if ($urandom_range(0, 1999) == 0) mute = ~mute;
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    for (int n = 0; n < FRAME && (underflow_count == 0 || !i2s_sclk); n++) @(negedge clk);
    repeat ($urandom_range(3, 60)) @(negedge clk);
    sample_valid = 1'b0;
    mute = 1'b0;
    reset = 1'b1;
    #2;
    check_eq("rst_uf", {16'd0, underflow_count}, 32'd0);
    check_eq("rst_ready", {31'd0, sample_ready}, 32'd0);
    check_eq("rst_sclk", {31'd0, i2s_sclk}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
